// File: rtl/raytracing_dispatcher.sv
// Raytracing frame dispatcher: launches worker batches across a frame,
// snapshots their colour buffers and streams pixels in raster order.
module raytracing_dispatcher #(
    parameter int N_WORKERS        = 8,
    parameter int JOBS_SUBDIVISION = 4,
    parameter int H_RES            = 640,
    parameter int V_RES            = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic                      worker_activate,
    output logic signed [11:0]        worker_x,
    output logic signed [11:0]        worker_y,
    input  logic [N_WORKERS-1:0]      worker_busy,
    input  logic [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0][11:0] worker_buffer,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [11:0]               pix_x,
    output logic [11:0]               pix_y,
    output logic [11:0]               pix_color
);

    localparam int B  = N_WORKERS * JOBS_SUBDIVISION;
    localparam int PW = (B > 1) ? $clog2(B) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [12:0]        H_LIM  = 13'(H_RES);
    localparam logic [PW-1:0]      P_LAST = PW'(B - 1);
    localparam logic signed [11:0] Y_LAST = 12'(V_RES - 1);

    logic [2:0]          state;
    logic [PW-1:0]       p;
    logic [B-1:0][11:0]  snap;

    logic        all_busy;
    logic        none_busy;
    logic [12:0] x_ext;
    logic [12:0] pix_x_ext;
    logic [12:0] batch_end;
    logic        last_pix;
    logic        row_end;
    logic        frame_end;
    logic        accept;

    // Batch/row bookkeeping in 13 bits so the clip tests never wrap
    always_comb begin
        all_busy  = &worker_busy;
        none_busy = ~|worker_busy;
        x_ext     = {1'b0, worker_x};
        pix_x_ext = x_ext + 13'(p);
        batch_end = x_ext + 13'(B);
        last_pix  = (p == P_LAST) || (pix_x_ext + 13'd1 >= H_LIM);
        row_end   = batch_end >= H_LIM;
        frame_end = worker_y == Y_LAST;
        accept    = (state == S_STREAM) && pix_ready;
    end

    // Outputs are pure functions of the state and the stream pointer
    always_comb begin
        frame_busy      = 1'b0;
        frame_done      = 1'b0;
        worker_activate = 1'b0;
        pix_valid       = 1'b0;
        unique case (state)
            S_LAUNCH: begin
                frame_busy      = 1'b1;
                worker_activate = 1'b1;
            end
            S_RUN: begin
                frame_busy      = 1'b1;
                worker_activate = 1'b1;
            end
            S_STREAM: begin
                frame_busy = 1'b1;
                pix_valid  = 1'b1;
            end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
        pix_x     = pix_x_ext[11:0];
        pix_y     = worker_y;
        pix_color = snap[p];
    end

    // Frame sequencer, coordinate counters and result snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            worker_x <= '0;
            worker_y <= '0;
            p        <= '0;
            snap     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        worker_x <= '0;
                        worker_y <= '0;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (all_busy) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (none_busy) begin
                        for (int i = 0; i < B; i++) begin
                            snap[i] <= worker_buffer[i % N_WORKERS][i / N_WORKERS];
                        end
                        p     <= '0;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (!last_pix) begin
                            p <= p + PW'(1);
                        end else begin
                            p <= '0;
                            if (!row_end) begin
                                worker_x <= batch_end[11:0];
                                state    <= S_LAUNCH;
                            end else if (!frame_end) begin
                                worker_x <= '0;
                                worker_y <= worker_y + 12'sd1;
                                state    <= S_LAUNCH;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raytracing_dispatcher.sv
// Scoreboard bench for raytracing_dispatcher with behavioural workers
// and a raster-order reference model of every frame.
module tb_raytracing_dispatcher;

    localparam int NW = 8;
    localparam int JS = 4;
    localparam int HR = 100;
    localparam int VR = 4;
    localparam int B  = NW * JS;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic frame_busy;
    logic frame_done;
    logic worker_activate;
    logic signed [11:0] worker_x;
    logic signed [11:0] worker_y;
    logic [NW-1:0] worker_busy;
    logic [NW-1:0][JS-1:0][11:0] worker_buffer;
    logic pix_valid;
    logic pix_ready = 1'b1;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [11:0] pix_color;

    raytracing_dispatcher #(
        .N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .H_RES(HR), .V_RES(VR)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .worker_activate(worker_activate),
        .worker_x(worker_x), .worker_y(worker_y),
        .worker_busy(worker_busy), .worker_buffer(worker_buffer),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [11:0] c;
    } pix_t;

    pix_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int seed_c     = 0;
    int done_cnt   = 0;
    int mbx        = 0;
    int mby        = 0;
    bit rnd_ready  = 0;
    int wdly[NW];

    function automatic logic [11:0] color_of(int x, int y, int s);
        int v;
        v = (x * 37 + y * 101 + s * 7) & 32'hFFF;
        return v[11:0];
    endfunction

    task automatic push_frame();
        for (int y = 0; y < VR; y++) begin
            for (int x = 0; x < HR; x++) begin
                pix_t e;
                e.x = x;
                e.y = y;
                e.c = color_of(x, y, seed_c);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural workers: busy rises after wdly cycles, falls 20 later
    int phase[NW];
    int cnt[NW];
    int bx[NW];
    int by[NW];
    always @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (rst) begin
                phase[i]         <= 0;
                worker_busy[i]   <= 1'b0;
                worker_buffer[i] <= '0;
            end else begin
                case (phase[i])
                    0: if (worker_activate) begin
                        bx[i] <= int'(worker_x) + i;
                        by[i] <= int'(worker_y);
                        if (wdly[i] <= 1) begin
                            worker_busy[i] <= 1'b1;
                            phase[i]       <= 2;
                            cnt[i]         <= 20;
                        end else begin
                            phase[i] <= 1;
                            cnt[i]   <= wdly[i] - 1;
                        end
                    end
                    1: if (cnt[i] <= 1) begin
                        worker_busy[i] <= 1'b1;
                        phase[i]       <= 2;
                        cnt[i]         <= 20;
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                    2: if (cnt[i] <= 1) begin
                        worker_busy[i] <= 1'b0;
                        phase[i]       <= 3;
                        for (int k = 0; k < JS; k++)
                            worker_buffer[i][k] <= color_of(bx[i] + k * NW, by[i], seed_c);
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                        for (int k = 0; k < JS; k++)
                            worker_buffer[i][k] <= 12'($urandom);
                    end
                    default: if (!worker_activate) begin
                        phase[i] <= 0;
                        for (int k = 0; k < JS; k++)
                            worker_buffer[i][k] <= 12'($urandom);
                    end
                endcase
            end
        end
    end

    // Downstream ready, optionally random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted pixel
    initial begin
        bit stall_prev;
        bit act_prev;
        logic [11:0] hx, hy, hc;
        pix_t e;
        stall_prev = 0;
        act_prev   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
                act_prev   = 0;
            end else begin
                if (frame_done) done_cnt++;
                if (stall_prev) begin
                    compared++;
                    if (!pix_valid || pix_x != hx || pix_y != hy || pix_color != hc) begin
                        mismatched++;
                        $display("FAIL hold: got v=%0b (%0d,%0d) c=%h expected (%0d,%0d) c=%h",
                                 pix_valid, pix_x, pix_y, pix_color, hx, hy, hc);
                    end
                end
                if (pix_valid) begin
                    compared++;
                    if (worker_activate || worker_busy != '0) begin
                        mismatched++;
                        $display("FAIL valid_gate: act=%0b busy=%h expected act=0 busy=0",
                                 worker_activate, worker_busy);
                    end
                end
                if (pix_valid && pix_ready) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL extra_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(pix_x) != e.x || int'(pix_y) != e.y || pix_color != e.c) begin
                            mismatched++;
                            $display("FAIL pixel: got (%0d,%0d) c=%h expected (%0d,%0d) c=%h",
                                     pix_x, pix_y, pix_color, e.x, e.y, e.c);
                        end
                    end
                end
                if (worker_activate && !act_prev) begin
                    compared++;
                    if (int'(worker_x) != mbx || int'(worker_y) != mby) begin
                        mismatched++;
                        $display("FAIL batch_base: got (%0d,%0d) expected (%0d,%0d)",
                                 worker_x, worker_y, mbx, mby);
                    end
                    if (mbx + B >= HR) begin
                        mbx = 0;
                        mby = (mby + 1) % VR;
                    end else begin
                        mbx = mbx + B;
                    end
                end
                act_prev   = worker_activate;
                stall_prev = pix_valid && !pix_ready;
                hx = pix_x;
                hy = pix_y;
                hc = pix_color;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 20000);
        check({tag, "_done_seen"}, int'(frame_done), 1);
    endtask

    initial begin
        int n;
        int base_done;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NW; i++) wdly[i] = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_activate", int'(worker_activate), 0);
        check("rst_frame_busy", int'(frame_busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_worker_x", int'(worker_x), 0);
        check("rst_worker_y", int'(worker_y), 0);

        // Frame 1: ready always high
        seed_c = 11;
        push_frame();
        pulse_start();
        @(negedge clk);
        check("f1_busy_after_start", int'(frame_busy), 1);
        check("f1_activate", int'(worker_activate), 1);
        wait_done("f1");
        check("f1_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("f1_done_one_cycle", int'(frame_done), 0);
        check("f1_idle_busy", int'(frame_busy), 0);

        // Frame 2: random stalls, slow worker, stray start during RUN
        rnd_ready = 1;
        wdly[3]   = 10;
        seed_c    = 222;
        push_frame();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(worker_activate && &worker_busy) && n < 2000);
        check("f2_all_busy_seen", int'(&worker_busy), 1);
        pulse_start();
        wait_done("f2");
        check("f2_queue_empty", exp_q.size(), 0);
        repeat (30) @(negedge clk);
        check("f2_no_restart", int'(frame_busy), 0);
        check("f2_done_count", done_cnt, 2);

        // Frame 3: reset at pixel 5 of row 3
        rnd_ready = 0;
        wdly[3]   = 1;
        seed_c    = 33;
        push_frame();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pix_valid && pix_x == 12'd5 && pix_y == 12'd3) && n < 20000);
        check("f3_reached_pixel", int'(pix_valid && pix_x == 12'd5 && pix_y == 12'd3), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_pix_valid", int'(pix_valid), 0);
        check("mid_rst_activate", int'(worker_activate), 0);
        check("mid_rst_frame_busy", int'(frame_busy), 0);
        rst = 1'b0;
        exp_q.delete();
        mbx = 0;
        mby = 0;
        repeat (5) @(negedge clk);
        check("post_rst_idle_valid", int'(pix_valid), 0);
        check("post_rst_idle_busy", int'(frame_busy), 0);
        seed_c = 44;
        push_frame();
        pulse_start();
        wait_done("f4");
        check("f4_queue_empty", exp_q.size(), 0);

        // Frames 5-6: start held high across the frame boundary
        seed_c = 55;
        push_frame();
        push_frame();
        @(posedge clk);
        #1 start = 1'b1;
        wait_done("f5");
        @(negedge clk);
        check("held_idle_busy", int'(frame_busy), 0);
        @(negedge clk);
        check("held_restart_busy", int'(frame_busy), 1);
        check("held_restart_act", int'(worker_activate), 1);
        #1 start = 1'b0;
        base_done = done_cnt;
        wait_done("f6");
        check("f6_queue_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        check("f6_stays_idle", int'(frame_busy), 0);
        check("f6_done_count", done_cnt - base_done, 1);
        check("total_done_count", done_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
